// File: rtl/if_id_skid_stage_if.sv
// Handshake/bus bundle for the IF/ID skid stage: fetch side (in_*) and decode side (out_*).
// The stage connects through the slave modport; the fetch/decode environment uses master.
interface if_id_skid_stage_if #(
  parameter int PC_WIDTH       = 32,
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [PC_WIDTH-1:0]       in_pc;
  logic [PC_WIDTH-1:0]       in_pc_next;
  logic [INST_WIDTH-1:0]     in_inst;

  logic                      out_valid;
  logic                      out_ready;
  logic [PC_WIDTH-1:0]       out_pc;
  logic [PC_WIDTH-1:0]       out_pc_next;
  logic [INST_WIDTH-1:0]     out_inst;
  logic [6:0]                out_opcode;
  logic [REG_ADDR_WIDTH-1:0] out_rs1;
  logic [REG_ADDR_WIDTH-1:0] out_rs2;
  logic [REG_ADDR_WIDTH-1:0] out_rd;

  modport slave (
    input  in_valid, in_pc, in_pc_next, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_pc_next, out_inst,
    output out_opcode, out_rs1, out_rs2, out_rd
  );

  modport master (
    output in_valid, in_pc, in_pc_next, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_next, out_inst,
    input  out_opcode, out_rs1, out_rs2, out_rd
  );
endinterface

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with valid/ready handshake, 2-entry skid buffer, flush and NOP masking.
// Optional perf counters (stall_cnt/flush_cnt) are built only when IF_ID_PERF_CNT_EN is defined.
//
//   state | meaning
//   EMPTY | no beat held, out_valid=0, out_inst shows NOP_INST
//   BUSY  | main entry holds the output beat, skid free
//   FULL  | main and skid both hold beats, in_ready=0
module if_id_skid_stage #(
  parameter int                    PC_WIDTH       = 32,
  parameter int                    INST_WIDTH     = 32,
  parameter int                    REG_ADDR_WIDTH = 5,
  parameter logic [INST_WIDTH-1:0] NOP_INST       = 32'h0000_0013,
  parameter int                    CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 perf_clr,
  if_id_skid_stage_if.slave    bus,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic                  in_fire;
  logic                  out_fire;
  logic                  load_main_in;
  logic                  load_main_skid;
  logic                  load_skid;

  logic [PC_WIDTH-1:0]   main_pc_q;
  logic [PC_WIDTH-1:0]   main_pc_next_q;
  logic [INST_WIDTH-1:0] main_inst_q;
  logic [PC_WIDTH-1:0]   skid_pc_q;
  logic [PC_WIDTH-1:0]   skid_pc_next_q;
  logic [INST_WIDTH-1:0] skid_inst_q;
  logic [INST_WIDTH-1:0] out_inst_w;

  // Handshake flags come from the state register alone, so in_ready never depends on out_ready.
  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_BUSY;
            load_main_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_EMPTY;
      main_pc_q      <= '0;
      main_pc_next_q <= '0;
      main_inst_q    <= '0;
      skid_pc_q      <= '0;
      skid_pc_next_q <= '0;
      skid_inst_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_pc_q      <= bus.in_pc;
        main_pc_next_q <= bus.in_pc_next;
        main_inst_q    <= bus.in_inst;
      end else if (load_main_skid) begin
        main_pc_q      <= skid_pc_q;
        main_pc_next_q <= skid_pc_next_q;
        main_inst_q    <= skid_inst_q;
      end
      if (load_skid) begin
        skid_pc_q      <= bus.in_pc;
        skid_pc_next_q <= bus.in_pc_next;
        skid_inst_q    <= bus.in_inst;
      end
    end
  end

  // Data regs are not cleared on flush; masking here hides stale contents.
  assign out_inst_w      = bus.out_valid ? main_inst_q : NOP_INST;
  assign bus.out_inst    = out_inst_w;
  assign bus.out_pc      = main_pc_q;
  assign bus.out_pc_next = main_pc_next_q;
  assign bus.out_opcode  = out_inst_w[6:0];
  assign bus.out_rs1     = out_inst_w[15 +: REG_ADDR_WIDTH];
  assign bus.out_rs2     = out_inst_w[20 +: REG_ADDR_WIDTH];
  assign bus.out_rd      = out_inst_w[7 +: REG_ADDR_WIDTH];

`ifdef IF_ID_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 stall_evt;
  logic                 flush_evt;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  assign stall_evt = bus.out_valid & ~bus.out_ready;
  // Only flushes that actually dropped a held beat are counted.
  assign flush_evt = flush & bus.out_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (perf_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_evt && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cnt       = '0;
  assign flush_cnt       = '0;
`endif

endmodule
